// File: rtl/count_capture_unit_pkg.sv
// Shared types and helpers for the count capture unit.
// Holds the capture FSM state encoding, the low-nibble width and the
// modulo-16 successor used by the sequence checker.
package count_capture_unit_pkg;

  localparam int unsigned LO_W = 4;

  typedef enum logic {
    IDLE = 1'b0,
    HOLD = 1'b1
  } cap_state_e;

  // Expected next upstream count; wraps 15 -> 0.
  function automatic logic [LO_W-1:0] lo_succ(input logic [LO_W-1:0] v);
    return v + LO_W'(1);
  endfunction

endpackage

// File: rtl/count_capture_unit_event_detect.sv
// Count event detector: samples the upstream count and extends it with a
// wrap counter. It also raises wrap and compare-match pulses and tracks
// upstream sequence faults.
// Ports:
//   clk, rst             clock, synchronous active-high reset
//   cnt_in               upstream 4-bit count
//   cmp_val, cmp_en      compare value / enable
//   cap_req              capture request (level)
//   ext_count            registered {hi, lo}
//   wrap_pulse           one-cycle pulse when ext_count first shows {hi+1, 0}
//   match_pulse          one-cycle pulse when ext_count first shows cmp_val
//   seq_err              sticky skipped/repeated count flag
//   snap_c               value ext_count will show next cycle
//   trig_c               capture trigger for this cycle
module count_event_detect
  import count_capture_unit_pkg::*;
#(
  parameter int unsigned HI_W     = 8,
  parameter bit          AUTO_CAP = 1'b0
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [LO_W-1:0]      cnt_in,
  input  logic [LO_W-1:0]      cmp_val,
  input  logic                 cmp_en,
  input  logic                 cap_req,
  output logic [HI_W+LO_W-1:0] ext_count,
  output logic                 wrap_pulse,
  output logic                 match_pulse,
  output logic                 seq_err,
  output logic [HI_W+LO_W-1:0] snap_c,
  output logic                 trig_c
);

  logic [LO_W-1:0] lo;
  logic [HI_W-1:0] hi;
  logic [HI_W-1:0] hi_next;
  logic            prev_valid;
  logic            wrap_c;
  logic            match_c;
  logic            seq_bad_c;

  // Event decode. prev_valid blocks every event on the first sample after reset.
  always_comb begin
    wrap_c    = prev_valid & (lo == '1) & (cnt_in == '0);
    // Rising equality only, so a count stalled on cmp_val does not re-fire.
    match_c   = cmp_en & prev_valid & (cnt_in == cmp_val) & (lo != cmp_val);
    seq_bad_c = prev_valid & (cnt_in != lo_succ(lo));
    hi_next   = wrap_c ? hi + HI_W'(1) : hi;
    snap_c    = {hi_next, cnt_in};
    trig_c    = cap_req | (AUTO_CAP & match_c);
  end

  // Sample registers and pulse outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      lo          <= '0;
      hi          <= '0;
      prev_valid  <= 1'b0;
      wrap_pulse  <= 1'b0;
      match_pulse <= 1'b0;
      seq_err     <= 1'b0;
    end else begin
      lo          <= cnt_in;
      hi          <= hi_next;
      prev_valid  <= 1'b1;
      wrap_pulse  <= wrap_c;
      match_pulse <= match_c;
      if (seq_bad_c) seq_err <= 1'b1;
    end
  end

  assign ext_count = {hi, lo};

endmodule

// File: rtl/count_capture_unit.sv
// Count capture unit: extends the upstream 4-bit count with a wrap counter.
// It pulses on wrap and on compare match, and holds captured timestamps
// for a valid/ready consumer.
// Ports:
//   clk, rst             clock, synchronous active-high reset
//   cnt_in               upstream 4-bit count
//   cmp_val, cmp_en      compare value / enable
//   cap_req              capture request, sampled every cycle
//   out_ready            downstream ready
//   ext_count            registered {hi, lo}, lags cnt_in by one cycle
//   wrap_pulse           one-cycle rollover pulse
//   match_pulse          one-cycle compare-match pulse
//   cap_data, cap_valid  captured timestamp and its valid flag
//   overrun              sticky; a capture was dropped while holding
//   seq_err              sticky; upstream count skipped or repeated
module count_capture_unit
  import count_capture_unit_pkg::*;
#(
  parameter int unsigned HI_W     = 8,
  parameter bit          AUTO_CAP = 1'b0
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [LO_W-1:0]      cnt_in,
  input  logic [LO_W-1:0]      cmp_val,
  input  logic                 cmp_en,
  input  logic                 cap_req,
  input  logic                 out_ready,
  output logic [HI_W+LO_W-1:0] ext_count,
  output logic                 wrap_pulse,
  output logic                 match_pulse,
  output logic [HI_W+LO_W-1:0] cap_data,
  output logic                 cap_valid,
  output logic                 overrun,
  output logic                 seq_err
);

  logic [HI_W+LO_W-1:0] snap_c;
  logic                 trig_c;

  cap_state_e           state;
  cap_state_e           state_next;
  logic [HI_W+LO_W-1:0] cap_data_next;
  logic                 overrun_next;

  count_event_detect #(
    .HI_W     (HI_W),
    .AUTO_CAP (AUTO_CAP)
  ) u_detect (
    .clk         (clk),
    .rst         (rst),
    .cnt_in      (cnt_in),
    .cmp_val     (cmp_val),
    .cmp_en      (cmp_en),
    .cap_req     (cap_req),
    .ext_count   (ext_count),
    .wrap_pulse  (wrap_pulse),
    .match_pulse (match_pulse),
    .seq_err     (seq_err),
    .snap_c      (snap_c),
    .trig_c      (trig_c)
  );

  // Capture FSM state register.
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  // Next-state and held-data decode.
  always_comb begin
    state_next    = state;
    cap_data_next = cap_data;
    overrun_next  = overrun;
    case (state)
      IDLE: begin
        if (trig_c) begin
          cap_data_next = snap_c;
          state_next    = HOLD;
        end
      end
      HOLD: begin
        if (out_ready) begin
          // Transfer completes; a simultaneous trigger reloads without a bubble.
          if (trig_c) cap_data_next = snap_c;
          else        state_next    = IDLE;
        end else if (trig_c) begin
          overrun_next = 1'b1;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // Output registers; cap_valid mirrors the state being entered.
  always_ff @(posedge clk) begin
    if (rst) begin
      cap_data  <= '0;
      cap_valid <= 1'b0;
      overrun   <= 1'b0;
    end else begin
      cap_data  <= cap_data_next;
      cap_valid <= (state_next == HOLD);
      overrun   <= overrun_next;
    end
  end

endmodule

// File: tb/tb_count_capture_unit.sv
// Self-checking bench for count_capture_unit. It drives one instance with
// AUTO_CAP=0 and one with AUTO_CAP=1 from the same inputs, and compares both
// against a behavioural model of the extended count and capture channel.
module tb_count_capture_unit;

  logic        clk;
  logic        rst;
  logic [3:0]  cnt_in;
  logic [3:0]  cmp_val;
  logic        cmp_en;
  logic        cap_req;
  logic        out_ready;

  logic [11:0] ext_a, data_a, ext_b, data_b;
  logic        wrap_a, match_a, valid_a, ovr_a, seq_a;
  logic        wrap_b, match_b, valid_b, ovr_b, seq_b;

  int n_vec;
  int n_miss;

  // Model state, index 0 = AUTO_CAP 0, index 1 = AUTO_CAP 1.
  int m_lo[2], m_hi[2], m_data[2];
  bit m_pv[2], m_wp[2], m_mp[2], m_seq[2], m_val[2], m_ovr[2];

  count_capture_unit #(.HI_W(8), .AUTO_CAP(1'b0)) dut (
    .clk(clk), .rst(rst), .cnt_in(cnt_in), .cmp_val(cmp_val), .cmp_en(cmp_en),
    .cap_req(cap_req), .out_ready(out_ready), .ext_count(ext_a),
    .wrap_pulse(wrap_a), .match_pulse(match_a), .cap_data(data_a),
    .cap_valid(valid_a), .overrun(ovr_a), .seq_err(seq_a)
  );

  count_capture_unit #(.HI_W(8), .AUTO_CAP(1'b1)) dut_auto (
    .clk(clk), .rst(rst), .cnt_in(cnt_in), .cmp_val(cmp_val), .cmp_en(cmp_en),
    .cap_req(cap_req), .out_ready(out_ready), .ext_count(ext_b),
    .wrap_pulse(wrap_b), .match_pulse(match_b), .cap_data(data_b),
    .cap_valid(valid_b), .overrun(ovr_b), .seq_err(seq_b)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_miss++;
      $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
    end
  endtask

  // Advance the model by one clock using the inputs presented at the edge.
  task automatic model_tick();
    int  c, hn, snap;
    bit  w, mt, tr;
    for (int k = 0; k < 2; k++) begin
      if (rst) begin
        m_lo[k] = 0; m_hi[k] = 0; m_data[k] = 0;
        m_pv[k] = 0; m_wp[k] = 0; m_mp[k] = 0;
        m_seq[k] = 0; m_val[k] = 0; m_ovr[k] = 0;
      end else begin
        c    = int'(cnt_in);
        w    = m_pv[k] && (m_lo[k] == 15) && (c == 0);
        mt   = cmp_en && m_pv[k] && (c == int'(cmp_val)) && (m_lo[k] != int'(cmp_val));
        hn   = (m_hi[k] + (w ? 1 : 0)) % 256;
        snap = hn * 16 + c;
        tr   = cap_req || ((k == 1) && mt);
        if (!m_val[k]) begin
          if (tr) begin m_val[k] = 1; m_data[k] = snap; end
        end else if (out_ready) begin
          if (tr) m_data[k] = snap;
          else    m_val[k]  = 0;
        end else if (tr) begin
          m_ovr[k] = 1;
        end
        if (m_pv[k] && (c != (m_lo[k] + 1) % 16)) m_seq[k] = 1;
        m_lo[k] = c; m_hi[k] = hn; m_pv[k] = 1; m_wp[k] = w; m_mp[k] = mt;
      end
    end
  endtask

  task automatic check_all();
    chk("ext_a",   32'(ext_a),   32'(m_hi[0] * 16 + m_lo[0]));
    chk("wrap_a",  32'(wrap_a),  32'(m_wp[0]));
    chk("match_a", 32'(match_a), 32'(m_mp[0]));
    chk("valid_a", 32'(valid_a), 32'(m_val[0]));
    chk("data_a",  32'(data_a),  32'(m_data[0]));
    chk("ovr_a",   32'(ovr_a),   32'(m_ovr[0]));
    chk("seq_a",   32'(seq_a),   32'(m_seq[0]));
    chk("ext_b",   32'(ext_b),   32'(m_hi[1] * 16 + m_lo[1]));
    chk("wrap_b",  32'(wrap_b),  32'(m_wp[1]));
    chk("match_b", 32'(match_b), 32'(m_mp[1]));
    chk("valid_b", 32'(valid_b), 32'(m_val[1]));
    chk("data_b",  32'(data_b),  32'(m_data[1]));
    chk("ovr_b",   32'(ovr_b),   32'(m_ovr[1]));
    chk("seq_b",   32'(seq_b),   32'(m_seq[1]));
  endtask

  task automatic step();
    @(posedge clk);
    model_tick();
    #1;
    check_all();
  endtask

  initial begin
    int wq[$];
    int nm;
    int ncap;
    clk = 0; rst = 1; cnt_in = 0; cmp_val = 0; cmp_en = 0; cap_req = 0; out_ready = 1;
    n_vec = 0; n_miss = 0;

    // Reset state
    step(); step();
    chk("rst_ext", 32'(ext_a), 0);
    chk("rst_valid", 32'(valid_a), 0);
    rst = 0;

    // Free run from 0 for 40 cycles
    for (int i = 0; i < 40; i++) begin
      cnt_in = 4'(i); step();
      if (wrap_a) wq.push_back(i);
    end
    chk("wrap_count", 32'(wq.size()), 2);
    chk("wrap_gap", 32'((wq.size() == 2) ? wq[1] - wq[0] : -1), 16);
    chk("ext_end", 32'(ext_a), 32'h027);
    chk("seq_clean", 32'(seq_a), 0);

    // Compare enabled at 5
    cmp_en = 1; cmp_val = 4'h5; nm = 0;
    for (int i = 40; i < 72; i++) begin
      cnt_in = 4'(i); step();
      if (match_a) begin nm++; chk("match_lo", 32'(ext_a[3:0]), 5); end
    end
    chk("match_count", 32'(nm), 2);
    cmp_en = 0; nm = 0;
    for (int i = 72; i < 88; i++) begin
      cnt_in = 4'(i); step();
      if (match_a) nm++;
    end
    chk("match_off", 32'(nm), 0);

    // Capture at cnt 9, hi 1, held with out_ready low
    rst = 1; step(); rst = 0; out_ready = 0;
    for (int i = 0; i < 25; i++) begin cnt_in = 4'(i); step(); end
    cnt_in = 4'd9; cap_req = 1; step(); cap_req = 0;
    chk("cap_valid", 32'(valid_a), 1);
    chk("cap_data", 32'(data_a), 32'h019);
    for (int i = 26; i < 36; i++) begin
      cnt_in = 4'(i); step();
      chk("hold_data", 32'(data_a), 32'h019);
    end
    cnt_in = 4'(36); cap_req = 1; step();
    chk("overrun", 32'(ovr_a), 1);
    chk("ovr_data", 32'(data_a), 32'h019);
    cnt_in = 4'(37); out_ready = 1; step();
    chk("b2b_valid", 32'(valid_a), 1);
    chk("b2b_data", 32'(data_a), 32'h025);
    cnt_in = 4'(38); cap_req = 0; step();
    chk("xfer_done", 32'(valid_a), 0);
    out_ready = 0;

    // Sequence fault: ...2, 3, 5
    for (int i = 39; i < 51; i++) begin cnt_in = 4'(i); step(); end
    cnt_in = 4'd3; step();
    chk("seq_before", 32'(seq_a), 0);
    cnt_in = 4'd5; step();
    chk("seq_set", 32'(seq_a), 1);
    for (int i = 6; i < 10; i++) begin
      cnt_in = 4'(i); step();
      chk("seq_sticky", 32'(seq_a), 1);
    end
    cnt_in = 4'd10; cap_req = 1; step(); cap_req = 0;
    chk("hold_pre_rst", 32'(valid_a), 1);
    rst = 1; step();
    chk("rst_all", 32'({ext_a, data_a, wrap_a, match_a, valid_a, ovr_a, seq_a}), 0);
    rst = 0;

    // Auto capture on compare 0xC with out_ready held
    cmp_en = 1; cmp_val = 4'hC; out_ready = 1; ncap = 0;
    for (int i = 0; i < 48; i++) begin
      cnt_in = 4'(i); step();
      if (valid_b) begin ncap++; chk("auto_lo", 32'(data_b[3:0]), 32'hC); end
    end
    chk("auto_caps", 32'(ncap), 3);

    // Randomized traffic
    for (int r = 0; r < 600; r++) begin
      rst       = ($urandom_range(0, 79) == 0);
      cnt_in    = ($urandom_range(0, 9) == 0) ? 4'($urandom) : cnt_in + 4'd1;
      cap_req   = ($urandom_range(0, 3) == 0);
      out_ready = 1'($urandom);
      if ($urandom_range(0, 15) == 0) cmp_en = 1'($urandom);
      if ($urandom_range(0, 15) == 0) cmp_val = 4'($urandom);
      step();
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
